// File: rtl/alu_op_sequencer_if.sv
// Command, ALU operand/control and response signals of the ALU op sequencer.
//   master : the sequencer (accepts commands, drives the ALU, issues responses)
//   slave  : the environment (issues commands, models the ALU, consumes responses)
interface alu_op_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_use_acc;

    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_ctrl;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_overflow;
    logic       alu_carry;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic [2:0] rsp_flags;
    logic       rsp_err;

    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc,
        output cmd_ready,
        output alu_a, alu_b, alu_ctrl,
        input  alu_result, alu_zero, alu_overflow, alu_carry,
        output rsp_valid, rsp_result, rsp_flags, rsp_err,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc,
        input  cmd_ready,
        input  alu_a, alu_b, alu_ctrl,
        output alu_result, alu_zero, alu_overflow, alu_carry,
        input  rsp_valid, rsp_result, rsp_flags, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Command-side initiator for the 8-bit ALU. Accepts one command at a time,
// drives registered operands/opcode to the ALU, waits ALU_LAT cycles, then
// captures result and flags into a held response. Keeps an accumulator that
// can replace operand A for chained operations.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   bus        : command / ALU / response signals (master side)
//   acc        : accumulator (last legal completed result)
//   op_count   : number of completed legal operations (wraps)
//
// state | meaning
// IDLE  | ready for a command (cmd_ready=1 once out of reset)
// ISSUE | ALU inputs held, settle counter running
// RESP  | response held until rsp_valid && rsp_ready
module alu_op_sequencer #(
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_op_sequencer_if.master bus,
    output logic [7:0]         acc,
    output logic [CNT_W-1:0]   op_count
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

    localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT);
    localparam logic [3:0] OP_MAX   = 4'hA;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [7:0]       alu_a_q, alu_a_d;
    logic [7:0]       alu_b_q, alu_b_d;
    logic [3:0]       alu_ctrl_q, alu_ctrl_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_result_q, rsp_result_d;
    logic [2:0]       rsp_flags_q, rsp_flags_d;
    logic             rsp_err_q, rsp_err_d;
    logic [7:0]       acc_q, acc_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    // Holds cmd_ready low until the first clock after reset release.
    logic             run_q;
    logic             cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
            acc_q        <= '0;
            op_count_q   <= '0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
            acc_q        <= acc_d;
            op_count_q   <= op_count_d;
            run_q        <= 1'b1;
        end
    end

    assign cmd_ready = run_q && (state_q == IDLE);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctrl_d   = alu_ctrl_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        acc_d        = acc_q;
        op_count_d   = op_count_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready) begin
                    if (bus.cmd_op <= OP_MAX) begin
                        alu_a_d    = bus.cmd_use_acc ? acc_q : bus.cmd_a;
                        alu_b_d    = bus.cmd_b;
                        alu_ctrl_d = bus.cmd_op;
                        cnt_d      = LAT_LOAD;
                        state_d    = ISSUE;
                    end else begin
                        // Illegal opcode: the ALU is never touched.
                        rsp_result_d = '0;
                        rsp_flags_d  = 3'b001;
                        rsp_err_d    = 1'b1;
                        rsp_valid_d  = 1'b1;
                        state_d      = RESP;
                    end
                end
            end
            ISSUE: begin
                if (cnt_q == 4'd1) begin
                    rsp_result_d = bus.alu_result;
                    rsp_flags_d  = {bus.alu_carry, bus.alu_overflow, bus.alu_zero};
                    rsp_err_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    acc_d        = bus.alu_result;
                    op_count_d   = op_count_q + CNT_W'(1);
                    cnt_d        = '0;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready  = cmd_ready;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_ctrl   = alu_ctrl_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign bus.rsp_err    = rsp_err_q;
    assign acc            = acc_q;
    assign op_count       = op_count_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_op_sequencer_if bus1();
    alu_op_sequencer_if bus4();
    logic [7:0]  acc1, acc4;
    logic [15:0] cnt1, cnt4;

    alu_op_sequencer #(.ALU_LAT(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .acc(acc1), .op_count(cnt1));
    alu_op_sequencer #(.ALU_LAT(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4), .acc(acc4), .op_count(cnt4));

    // Reference ALU: returns {carry, overflow, zero, result}
    function automatic logic [10:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        logic [8:0] w;
        logic [7:0] r;
        logic c, o;
        w = '0; r = '0; c = 1'b0; o = 1'b0;
        case (op)
            4'h0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
                        o = (a[7] == b[7]) && (r[7] != a[7]); end
            4'h1: begin r = a - b; c = (a < b); o = (a[7] != b[7]) && (r[7] != a[7]); end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h5: begin r = {a[6:0], 1'b0}; c = a[7]; end
            4'h6: begin r = {1'b0, a[7:1]}; c = a[0]; end
            4'h7: r = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
            4'h8: begin r = a + 8'd1; c = (a == 8'hFF); o = (a == 8'h7F); end
            4'h9: begin r = a - 8'd1; c = (a == 8'h00); o = (a == 8'h80); end
            default: r = ~a;
        endcase
        return {c, o, (r == 8'd0), r};
    endfunction

    always_comb {bus1.alu_carry, bus1.alu_overflow, bus1.alu_zero, bus1.alu_result} =
        alu_f(bus1.alu_ctrl, bus1.alu_a, bus1.alu_b);
    always_comb {bus4.alu_carry, bus4.alu_overflow, bus4.alu_zero, bus4.alu_result} =
        alu_f(bus4.alu_ctrl, bus4.alu_a, bus4.alu_b);

    typedef struct {
        logic [7:0]  res;
        logic [2:0]  flags;
        logic        err;
        logic [7:0]  acc;
        logic [15:0] cnt;
        logic [7:0]  alu_a;
        logic [3:0]  alu_ctrl;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    logic [7:0]  acc_m, alu_a_m;
    logic [3:0]  alu_ctrl_m;
    logic [15:0] cnt_m;
    int n_checks = 0;
    int n_pass   = 0;

    // Drives one command to dut1 and pushes the expected response. lat is the
    // number of edges after the accept edge before rsp_valid is seen
    // (-1: never accepted, 99: no response).
    task automatic exec1(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic ua, output int lat);
        exp_t e;
        logic [10:0] r;
        logic [7:0] opa;
        opa = ua ? acc_m : a;
        if (op <= 4'hA) begin
            r = alu_f(op, opa, b);
            e.res = r[7:0]; e.flags = r[10:8]; e.err = 1'b0; e.lat = 1;
            acc_m = r[7:0]; cnt_m = cnt_m + 16'd1; alu_a_m = opa; alu_ctrl_m = op;
        end else begin
            e.res = 8'h00; e.flags = 3'b001; e.err = 1'b1; e.lat = 0;
        end
        e.acc = acc_m; e.cnt = cnt_m; e.alu_a = alu_a_m; e.alu_ctrl = alu_ctrl_m;
        sb_q.push_back(e);
        @(negedge clk);
        bus1.cmd_op = op; bus1.cmd_a = a; bus1.cmd_b = b; bus1.cmd_use_acc = ua;
        bus1.cmd_valid = 1'b1;
        lat = -1;
        for (int k = 0; k < 20 && !bus1.cmd_ready; k++) @(negedge clk);
        if (bus1.cmd_ready) begin
            @(posedge clk); #1 bus1.cmd_valid = 1'b0;
            @(negedge clk);
            lat = 0;
            while (!bus1.rsp_valid && lat < 40) begin @(negedge clk); lat++; end
            if (!bus1.rsp_valid) lat = 99;
        end else bus1.cmd_valid = 1'b0;
    endtask

    task automatic exec4(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output int lat);
        @(negedge clk);
        bus4.cmd_op = op; bus4.cmd_a = a; bus4.cmd_b = b; bus4.cmd_use_acc = 1'b0;
        bus4.cmd_valid = 1'b1;
        lat = -1;
        for (int k = 0; k < 20 && !bus4.cmd_ready; k++) @(negedge clk);
        if (bus4.cmd_ready) begin
            @(posedge clk); #1 bus4.cmd_valid = 1'b0;
            @(negedge clk);
            lat = 0;
            while (!bus4.rsp_valid && lat < 40) begin @(negedge clk); lat++; end
            if (!bus4.rsp_valid) lat = 99;
        end else bus4.cmd_valid = 1'b0;
    endtask

    task automatic ack1();
        bus1.rsp_ready = 1'b1;
        @(posedge clk); #1 bus1.rsp_ready = 1'b0;
    endtask

    task automatic ack4();
        bus4.rsp_ready = 1'b1;
        @(posedge clk); #1 bus4.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        acc_m = '0; cnt_m = '0; alu_a_m = '0; alu_ctrl_m = '0;
        #12;
        n_checks++; if (bus1.cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready: got %0h expected 0", bus1.cmd_ready); else n_pass++;
        n_checks++; if ({bus1.alu_a, bus1.alu_b, bus1.alu_ctrl} !== 20'h0) $display("FAIL rst_alu: got %0h expected 0", {bus1.alu_a, bus1.alu_b, bus1.alu_ctrl}); else n_pass++;
        n_checks++; if ({bus1.rsp_valid, bus1.rsp_result, bus1.rsp_flags, bus1.rsp_err} !== 13'h0) $display("FAIL rst_rsp: got %0h expected 0", {bus1.rsp_valid, bus1.rsp_result, bus1.rsp_flags, bus1.rsp_err}); else n_pass++;
        n_checks++; if (acc1 !== 8'h00) $display("FAIL rst_acc: got %0h expected 0", acc1); else n_pass++;
        n_checks++; if (cnt1 !== 16'h0) $display("FAIL rst_op_count: got %0h expected 0", cnt1); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        #1;
        n_checks++; if (bus1.cmd_ready !== 1'b0) $display("FAIL rel_cmd_ready_before_clk: got %0h expected 0", bus1.cmd_ready); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus1.cmd_ready !== 1'b1) $display("FAIL rel_cmd_ready_after_clk: got %0h expected 1", bus1.cmd_ready); else n_pass++;
    endtask

    typedef struct packed {logic [3:0] op; logic [7:0] a; logic [7:0] b; logic ua;} cmd_t;

    task automatic test_ops();
        cmd_t tbl[7];
        exp_t e;
        int lat;
        tbl = '{'{4'h0, 8'h7F, 8'h01, 1'b0},   // add overflow -> 80, flags 010
                '{4'h1, 8'h05, 8'h05, 1'b0},   // subtract to zero
                '{4'h0, 8'h10, 8'h20, 1'b0},   // 0x30
                '{4'h8, 8'hFF, 8'h00, 1'b1},   // inc of acc -> 0x31
                '{4'h1, 8'h03, 8'h05, 1'b0},   // borrow
                '{4'h7, 8'h00, 8'h01, 1'b1},   // SLT on acc (-2 < 1)
                '{4'h4, 8'h00, 8'hFF, 1'b1}};  // xor on acc
        foreach (tbl[i]) begin
            exec1(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ua, lat);
            e = sb_q.pop_front();
            n_checks++; if (lat !== e.lat) $display("FAIL op%0d_latency: got %0d expected %0d", i, lat, e.lat); else n_pass++;
            n_checks++; if (bus1.rsp_result !== e.res) $display("FAIL op%0d_result: got %0h expected %0h", i, bus1.rsp_result, e.res); else n_pass++;
            n_checks++; if (bus1.rsp_flags !== e.flags) $display("FAIL op%0d_flags: got %0b expected %0b", i, bus1.rsp_flags, e.flags); else n_pass++;
            n_checks++; if (bus1.rsp_err !== e.err) $display("FAIL op%0d_err: got %0h expected %0h", i, bus1.rsp_err, e.err); else n_pass++;
            n_checks++; if (acc1 !== e.acc) $display("FAIL op%0d_acc: got %0h expected %0h", i, acc1, e.acc); else n_pass++;
            n_checks++; if (cnt1 !== e.cnt) $display("FAIL op%0d_op_count: got %0d expected %0d", i, cnt1, e.cnt); else n_pass++;
            n_checks++; if (bus1.alu_a !== e.alu_a) $display("FAIL op%0d_alu_a: got %0h expected %0h", i, bus1.alu_a, e.alu_a); else n_pass++;
            ack1();
        end
    endtask

    task automatic test_illegal();
        exp_t e;
        int lat;
        exec1(4'hC, 8'h12, 8'h34, 1'b1, lat);
        e = sb_q.pop_front();
        n_checks++; if (lat !== e.lat) $display("FAIL ill_latency: got %0d expected %0d", lat, e.lat); else n_pass++;
        n_checks++; if (bus1.rsp_err !== 1'b1) $display("FAIL ill_err: got %0h expected 1", bus1.rsp_err); else n_pass++;
        n_checks++; if (bus1.rsp_result !== e.res) $display("FAIL ill_result: got %0h expected %0h", bus1.rsp_result, e.res); else n_pass++;
        n_checks++; if (bus1.rsp_flags !== e.flags) $display("FAIL ill_flags: got %0b expected %0b", bus1.rsp_flags, e.flags); else n_pass++;
        n_checks++; if (acc1 !== e.acc) $display("FAIL ill_acc: got %0h expected %0h", acc1, e.acc); else n_pass++;
        n_checks++; if (cnt1 !== e.cnt) $display("FAIL ill_op_count: got %0d expected %0d", cnt1, e.cnt); else n_pass++;
        n_checks++; if (bus1.alu_ctrl !== e.alu_ctrl) $display("FAIL ill_alu_ctrl: got %0h expected %0h", bus1.alu_ctrl, e.alu_ctrl); else n_pass++;
        n_checks++; if (bus1.alu_a !== e.alu_a) $display("FAIL ill_alu_a: got %0h expected %0h", bus1.alu_a, e.alu_a); else n_pass++;
        ack1();
    endtask

    task automatic test_backpressure();
        exp_t e;
        int lat;
        exec1(4'h3, 8'h0F, 8'hA0, 1'b0, lat);
        e = sb_q.pop_front();
        n_checks++; if (lat !== e.lat) $display("FAIL bp_latency: got %0d expected %0d", lat, e.lat); else n_pass++;
        bus1.cmd_op = 4'h0; bus1.cmd_a = 8'h01; bus1.cmd_b = 8'h01; bus1.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (bus1.rsp_valid !== 1'b1) $display("FAIL bp_hold%0d_valid: got %0h expected 1", i, bus1.rsp_valid); else n_pass++;
            n_checks++; if ({bus1.rsp_result, bus1.rsp_flags, bus1.rsp_err} !== {e.res, e.flags, e.err}) $display("FAIL bp_hold%0d_fields: got %0h expected %0h", i, {bus1.rsp_result, bus1.rsp_flags, bus1.rsp_err}, {e.res, e.flags, e.err}); else n_pass++;
            n_checks++; if (bus1.cmd_ready !== 1'b0) $display("FAIL bp_hold%0d_cmd_ready: got %0h expected 0", i, bus1.cmd_ready); else n_pass++;
        end
        ack1();
        @(negedge clk);
        n_checks++; if (bus1.rsp_valid !== 1'b0) $display("FAIL bp_after_valid: got %0h expected 0", bus1.rsp_valid); else n_pass++;
        n_checks++; if (bus1.cmd_ready !== 1'b1) $display("FAIL bp_after_cmd_ready: got %0h expected 1", bus1.cmd_ready); else n_pass++;
        n_checks++; if (cnt1 !== cnt_m) $display("FAIL bp_no_overlap_count: got %0d expected %0d", cnt1, cnt_m); else n_pass++;
        bus1.cmd_valid = 1'b0;
    endtask

    task automatic test_reset_midop();
        exp_t e;
        int lat;
        int pulses;
        e.res = 8'h42; e.flags = 3'b000; e.err = 1'b0; e.acc = 8'h42; e.cnt = 16'd1;
        e.alu_a = 8'h40; e.alu_ctrl = 4'h0; e.lat = 4;
        sb_q.push_back(e);
        exec4(4'h0, 8'h40, 8'h02, lat);
        e = sb_q.pop_front();
        n_checks++; if (lat !== e.lat) $display("FAIL lat4_latency: got %0d expected %0d", lat, e.lat); else n_pass++;
        n_checks++; if (bus4.rsp_result !== e.res) $display("FAIL lat4_result: got %0h expected %0h", bus4.rsp_result, e.res); else n_pass++;
        n_checks++; if (cnt4 !== e.cnt) $display("FAIL lat4_op_count: got %0d expected %0d", cnt4, e.cnt); else n_pass++;
        ack4();
        @(negedge clk);
        bus4.cmd_op = 4'h1; bus4.cmd_a = 8'h09; bus4.cmd_b = 8'h02; bus4.cmd_valid = 1'b1;
        for (int k = 0; k < 20 && !bus4.cmd_ready; k++) @(negedge clk);
        @(posedge clk); #1 bus4.cmd_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (bus4.cmd_ready !== 1'b0) $display("FAIL mid_cmd_ready: got %0h expected 0", bus4.cmd_ready); else n_pass++;
        n_checks++; if ({bus4.alu_a, bus4.alu_b, bus4.alu_ctrl} !== 20'h0) $display("FAIL mid_alu: got %0h expected 0", {bus4.alu_a, bus4.alu_b, bus4.alu_ctrl}); else n_pass++;
        n_checks++; if ({bus4.rsp_valid, bus4.rsp_result, bus4.rsp_flags, bus4.rsp_err} !== 13'h0) $display("FAIL mid_rsp: got %0h expected 0", {bus4.rsp_valid, bus4.rsp_result, bus4.rsp_flags, bus4.rsp_err}); else n_pass++;
        n_checks++; if ({acc4, cnt4} !== 24'h0) $display("FAIL mid_acc_count: got %0h expected 0", {acc4, cnt4}); else n_pass++;
        pulses = 0;
        repeat (3) begin @(negedge clk); pulses += int'(bus4.rsp_valid); end
        rst_n = 1'b1;
        repeat (8) begin @(negedge clk); pulses += int'(bus4.rsp_valid); end
        n_checks++; if (pulses !== 0) $display("FAIL mid_no_rsp_pulse: got %0d expected 0", pulses); else n_pass++;
        e.res = 8'h33; e.flags = 3'b000; e.err = 1'b0; e.acc = 8'h33; e.cnt = 16'd1;
        e.alu_a = 8'h22; e.alu_ctrl = 4'h0; e.lat = 4;
        sb_q.push_back(e);
        exec4(4'h0, 8'h22, 8'h11, lat);
        e = sb_q.pop_front();
        n_checks++; if (lat !== e.lat) $display("FAIL post_latency: got %0d expected %0d", lat, e.lat); else n_pass++;
        n_checks++; if (bus4.rsp_result !== e.res) $display("FAIL post_result: got %0h expected %0h", bus4.rsp_result, e.res); else n_pass++;
        n_checks++; if (cnt4 !== e.cnt) $display("FAIL post_op_count: got %0d expected %0d", cnt4, e.cnt); else n_pass++;
        n_checks++; if (acc4 !== e.acc) $display("FAIL post_acc: got %0h expected %0h", acc4, e.acc); else n_pass++;
        ack4();
    endtask

    initial begin
        rst_n = 1'b0;
        bus1.cmd_valid = 1'b0; bus1.cmd_op = '0; bus1.cmd_a = '0; bus1.cmd_b = '0;
        bus1.cmd_use_acc = 1'b0; bus1.rsp_ready = 1'b0;
        bus4.cmd_valid = 1'b0; bus4.cmd_op = '0; bus4.cmd_a = '0; bus4.cmd_b = '0;
        bus4.cmd_use_acc = 1'b0; bus4.rsp_ready = 1'b0;
        test_reset();
        test_ops();
        test_illegal();
        test_backpressure();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
